// File: rtl/line_mem_pkg.sv
// Shared types and default sizes for the cache-line memory arbiter.
//   arb_state_t : arbiter FSM states
//   port_t      : requester identity (instruction cache / data cache)
package line_mem_pkg;

    localparam int ADDR_W_DEF   = 32;
    localparam int LINE_W_DEF   = 256;
    localparam int OFFSET_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2,
        GAP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

endpackage

// File: rtl/line_mem_arbiter_rr_grant2.sv
// Two-requester round-robin picker, purely combinational.
//   req_i, req_d : request from instruction / data cache
//   last_grant   : port served most recently
//   grant_valid  : at least one request present
//   grant        : chosen port (meaningful only when grant_valid=1)
module rr_grant2
    import line_mem_pkg::*;
(
    input  logic  req_i,
    input  logic  req_d,
    input  port_t last_grant,
    output logic  grant_valid,
    output port_t grant
);

    always_comb begin
        grant_valid = req_i | req_d;
        if (req_i && req_d) begin
            grant = (last_grant == PORT_I) ? PORT_D : PORT_I;
        end else if (req_d) begin
            grant = PORT_D;
        end else begin
            grant = PORT_I;
        end
    end

endmodule

// File: rtl/line_mem_arbiter.sv
// Arbitrates icache (read-only) and dcache (read/write) line transfers onto
// one physical-memory line port. The winning request is latched into the
// pmem output registers so memory sees bit-stable inputs for the whole
// transaction.
//   clk, rst_n                : clock, async active-low reset
//   i_read/i_address          : icache request; i_resp/i_rdata completion
//   d_read/d_write/d_address/
//   d_wdata                   : dcache request; d_resp/d_rdata completion
//   pmem_*                    : physical memory line port
//   arb_error                 : sticky memory-error flag
//
// state | meaning
// IDLE  | waiting for a request, strobes low
// BUSY  | transaction in flight, pmem inputs frozen
// ERR   | memory flagged an error, waiting for it to clear
// GAP   | one dead cycle with strobes low before accepting again
module line_mem_arbiter
    import line_mem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int LINE_W   = LINE_W_DEF,
    parameter int OFFSET_W = OFFSET_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic              pmem_error,
    input  logic [LINE_W-1:0] pmem_rdata,
    output logic              arb_error
);

    localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFFSET_W;

    arb_state_t state;
    port_t      last_grant;
    port_t      grant_port;
    port_t      pick;
    logic       pick_valid;
    logic       resp_fire;
    logic       resp_pass;

    rr_grant2 u_rr_grant2 (
        .req_i       (i_read),
        .req_d       (d_read | d_write),
        .last_grant  (last_grant),
        .grant_valid (pick_valid),
        .grant       (pick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant   <= PORT_I;
            grant_port   <= PORT_I;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            arb_error    <= 1'b0;
        end else begin
            if (pmem_error) begin
                arb_error <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_port <= pick;
                        state      <= BUSY;
                        if (pick == PORT_D) begin
                            // read+write together resolves to a write
                            pmem_address <= d_address & LINE_MASK;
                            pmem_write   <= d_write;
                            pmem_read    <= ~d_write;
                            pmem_wdata   <= d_write ? d_wdata : '0;
                        end else begin
                            pmem_address <= i_address & LINE_MASK;
                            pmem_write   <= 1'b0;
                            pmem_read    <= 1'b1;
                            pmem_wdata   <= '0;
                        end
                    end
                end
                BUSY: begin
                    // error takes priority over a coincident completion
                    if (pmem_error) begin
                        state <= ERR;
                    end else if (pmem_resp) begin
                        last_grant <= grant_port;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                        state      <= GAP;
                    end
                end
                ERR: begin
                    if (!pmem_error) begin
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                        state      <= GAP;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Completion is combinational so the requester sees it in the same
    // cycle memory answers; an error completion returns a zero line.
    always_comb begin
        resp_fire = 1'b0;
        resp_pass = 1'b0;
        if (state == BUSY && !pmem_error && pmem_resp) begin
            resp_fire = 1'b1;
            resp_pass = 1'b1;
        end else if (state == ERR && !pmem_error) begin
            resp_fire = 1'b1;
        end
        i_resp  = resp_fire && (grant_port == PORT_I);
        d_resp  = resp_fire && (grant_port == PORT_D);
        i_rdata = (i_resp && resp_pass) ? pmem_rdata : '0;
        d_rdata = (d_resp && resp_pass) ? pmem_rdata : '0;
    end

endmodule

// File: doc/line_mem_arbiter.md
Name: line_mem_arbiter

Overview:
- Arbitrates 256-bit cache-line transfers from the instruction cache (read-only port) and the data cache (read/write port) onto the single physical-memory line port.
- Sits directly upstream of physical memory.
- Latches the winning request so pmem inputs stay bit-stable for the whole transaction, which the memory requires; any change mid-transaction is a memory error.
- Round-robin between ports when both request together; recovers cleanly from memory error.

Parameters:
- ADDR_W, 32, byte address width
- LINE_W, 256, line data width
- OFFSET_W, 5, line-offset bits cleared on pmem_address

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_read  in  1  icache line read request
- i_address  in  ADDR_W  icache byte address
- i_resp  out  1  icache completion pulse
- i_rdata  out  LINE_W  icache read line, valid when i_resp=1
- d_read  in  1  dcache line read request
- d_write  in  1  dcache line write request
- d_address  in  ADDR_W  dcache byte address
- d_wdata  in  LINE_W  dcache write line
- d_resp  out  1  dcache completion pulse
- d_rdata  out  LINE_W  dcache read line, valid when d_resp=1
- pmem_read  out  1  memory read strobe
- pmem_write  out  1  memory write strobe
- pmem_address  out  ADDR_W  line-aligned address
- pmem_wdata  out  LINE_W  write line
- pmem_resp  in  1  memory completion
- pmem_error  in  1  memory protocol error
- pmem_rdata  in  LINE_W  memory read line
- arb_error  out  1  sticky; set on any pmem_error, cleared only by reset

Behaviour:
Reset (asynchronous, rst_n=0):
- state=IDLE, last_grant=I.
- All outputs 0, including the latched address/wdata registers.

IDLE:
- No request: stay in IDLE.
- Exactly one port requests: grant that port.
- Both request: grant the port not equal to last_grant.
- On grant, latch the following, then go to BUSY next edge:
  - addr = requester address with low OFFSET_W bits zeroed
  - op = read or write (d_read and d_write both high means write)
  - wdata = d_wdata for writes, 0 otherwise
- pmem strobes are 0 during IDLE.

BUSY:
- pmem_read/pmem_write/pmem_address/pmem_wdata are driven only from the latched registers and are constant every cycle of BUSY.
- Requester inputs are ignored.
- pmem_resp=1:
  - Granted port's resp=1 in that same cycle (combinational).
  - Its rdata = pmem_rdata (passthrough).
  - The other port's resp stays 0.
  - last_grant updates to the granted port; next state GAP.
- pmem_error=1 (checked before pmem_resp): set arb_error, next state ERR.

ERR:
- Strobes held at latched values.
- Wait until pmem_error=0, then pulse the granted port's resp for one cycle with rdata=0, and go to GAP.
- The requester sees completion, never a hang.

GAP:
- One cycle with strobes 0, so memory returns to idle before a new request.
- All request inputs ignored; a requester still asserting in this cycle is not double-served.
- Next state IDLE.

Timing:
- Request in IDLE at edge N: strobes first visible in cycle N+1.
- resp comes memory-latency cycles later.
- Minimum spacing between two transactions: resp cycle + GAP + IDLE.

Other rules:
- At most one resp output is high in any cycle.
- pmem_read and pmem_write are never both 1.
- Reset asserted during BUSY/ERR/GAP drops strobes immediately (asynchronously) and discards the transaction; no resp is issued.

Decomposition:
- Package line_mem_pkg holds:
  - arb_state_t enum (IDLE, BUSY, ERR, GAP)
  - port_t enum (PORT_I, PORT_D)
  - LINE_W/ADDR_W/OFFSET_W defaults
- One natural sub-module: rr_grant2, a combinational two-request round-robin picker taking last_grant.
- Everything else is flat in line_mem_arbiter.

Test Plan:
- Memory model: fixed 25-cycle latency; it flags any input change during BUSY via pmem_error.
- i_read, address 0x0000_1234 -> pmem_address=0x0000_1220, pmem_read=1 stable for 25 cycles; i_resp one cycle with the model's line; d_resp stays 0.
- d_write, address 0x80, wdata all-0xA5 -> pmem_write=1 and pmem_wdata stable throughout; d_resp pulse. A following d_read of 0x80 returns all-0xA5.
- i_read and d_read asserted on the same edge after reset (last_grant=I) -> D served first, then I. Held-high requests alternate D,I,D,I across 4 transactions; one GAP cycle with strobes 0 between each.
- Bench inverts the model's view of pmem_address bit 7 mid-transaction -> pmem_error; arb_error=1 and remains set; the granted port gets exactly one resp after error drops; the next request completes normally.
- rst_n pulled low 10 cycles into a d_write -> strobes 0 asynchronously, no d_resp, state IDLE. After release, an i_read completes with no error.
- Requester keeps i_read high one cycle past i_resp -> exactly one transaction issued (GAP absorbs it); the second pmem_read rises only if i_read is still high in IDLE.
